// File: rtl/mul_pipe_pkg.sv
// Shared widths, instruction-type encodings and the payload layout for the
// multiplier M-stage register chain.
package mul_pipe_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ROB_IDX_W_DEF = 4;
  localparam int EXC_W_DEF     = 3;
  localparam int TYPE_W_DEF    = 3;

  // Instruction type encodings; zero marks a slot that carries no multiply.
  localparam logic [TYPE_W_DEF-1:0] INSTR_NOT_MUL = 3'd0;
  localparam logic [TYPE_W_DEF-1:0] INSTR_MUL     = 3'd1;
  localparam logic [TYPE_W_DEF-1:0] INSTR_MULH    = 3'd2;
  localparam logic [TYPE_W_DEF-1:0] INSTR_MULHSU  = 3'd3;
  localparam logic [TYPE_W_DEF-1:0] INSTR_MULHU   = 3'd4;

  // Payload as carried at the default widths (result, ROB tag, exceptions, type).
  typedef struct packed {
    logic [DATA_W_DEF-1:0]    mul_out;
    logic [ROB_IDX_W_DEF-1:0] rob_idx;
    logic [EXC_W_DEF-1:0]     exception_vector;
    logic [TYPE_W_DEF-1:0]    instr_type;
  } mul_payload_t;

endpackage

// File: rtl/mul_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus payload, loaded when the
// advance chain allows it and cleared by flush.
module mul_pipe_stage
  import mul_pipe_pkg::*;
#(
  parameter int PAY_W  = 39,
  parameter int TYPE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_v,
  input  logic [PAY_W-1:0]  i_pay,
  input  logic [TYPE_W-1:0] i_typ,
  output logic              o_v,
  output logic [PAY_W-1:0]  o_pay,
  output logic [TYPE_W-1:0] o_typ
);

  localparam logic [TYPE_W-1:0] TYP_NONE = TYPE_W'(INSTR_NOT_MUL);

  logic              r_v;
  logic [PAY_W-1:0]  r_pay;
  logic [TYPE_W-1:0] r_typ;

  // Slot register: flush beats load; a loaded bubble keeps the old data but
  // drops the instruction type so nothing downstream mistakes it for a multiply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v   <= 1'b0;
      r_pay <= '0;
      r_typ <= TYP_NONE;
    end else if (i_flush) begin
      r_v   <= 1'b0;
      r_typ <= TYP_NONE;
    end else if (i_load) begin
      r_v <= i_v;
      if (i_v) begin
        r_pay <= i_pay;
        r_typ <= i_typ;
      end else begin
        r_typ <= TYP_NONE;
      end
    end
  end

  assign o_v   = r_v;
  assign o_pay = r_pay;
  assign o_typ = r_typ;

endmodule

// File: rtl/mul_pipe_regs_n.sv
// DEPTH-stage elastic register chain for multiplier results and their ROB
// metadata, with bubble collapsing, global flush and an occupancy counter.
module mul_pipe_regs_n
  import mul_pipe_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int EXC_W     = EXC_W_DEF,
  parameter int TYPE_W    = TYPE_W_DEF,
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_mul_out,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [EXC_W-1:0]     in_exception_vector,
  input  logic [TYPE_W-1:0]    in_instr_type,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_mul_out,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [EXC_W-1:0]     out_exception_vector,
  output logic [TYPE_W-1:0]    out_instr_type,
  output logic [OCC_W-1:0]     out_occupancy
);

  // Everything except instr_type travels as one flat vector through the slots.
  localparam int PAY_W = DATA_W + ROB_IDX_W + EXC_W;

  logic [DEPTH-1:0]  w_v;
  logic [DEPTH-1:0]  w_adv;
  logic [PAY_W-1:0]  w_pay [DEPTH];
  logic [TYPE_W-1:0] w_typ [DEPTH];
  logic [PAY_W-1:0]  w_in_pay;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [OCC_W-1:0]  r_occ;

  assign w_in_pay = {in_mul_out, in_rob_idx, in_exception_vector};

  // Stage k may advance if it or any later stage is empty, or the output drains;
  // written as an OR over the tail so the chain has no self-referencing net.
  always_comb begin
    w_adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic acc;
      acc = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        acc = acc | ~w_v[j];
      end
      w_adv[k] = acc;
    end
  end

  assign in_ready   = w_adv[0];
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              w_src_v;
    logic [PAY_W-1:0]  w_src_pay;
    logic [TYPE_W-1:0] w_src_typ;

    if (k == 0) begin : g_head
      assign w_src_v   = in_valid;
      assign w_src_pay = w_in_pay;
      assign w_src_typ = in_instr_type;
    end else begin : g_body
      assign w_src_v   = w_v[k-1];
      assign w_src_pay = w_pay[k-1];
      assign w_src_typ = w_typ[k-1];
    end

    mul_pipe_stage #(
      .PAY_W  (PAY_W),
      .TYPE_W (TYPE_W)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_adv[k]),
      .i_flush (flush),
      .i_v     (w_src_v),
      .i_pay   (w_src_pay),
      .i_typ   (w_src_typ),
      .o_v     (w_v[k]),
      .o_pay   (w_pay[k]),
      .o_typ   (w_typ[k])
    );
  end

  // Occupancy tracks accepted minus delivered entries; flush empties the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign out_valid            = w_v[DEPTH-1];
  assign out_mul_out          = w_pay[DEPTH-1][PAY_W-1 -: DATA_W];
  assign out_rob_idx          = w_pay[DEPTH-1][EXC_W +: ROB_IDX_W];
  assign out_exception_vector = w_pay[DEPTH-1][EXC_W-1:0];
  assign out_instr_type       = w_typ[DEPTH-1];
  assign out_occupancy        = r_occ;

endmodule
